// File: rtl/sequencia_memoria.sv
// Memory-game sequence store: appends one-hot values, plays them on the LEDs, then checks player presses.
// Optional macro SEQ_TIMEOUT_EN adds a player inactivity timeout in ESPERA_JOGADA.
module sequencia_memoria #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int T_ON    = 4,
    parameter int T_OFF   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          zera_s_n,
    input  logic          adiciona,
    input  logic [3:0]    numero,
    input  logic          mostra,
    input  logic [3:0]    jogada,
    input  logic          jogada_valida,
    output logic [3:0]    leds,
    output logic [AW:0]   tamanho,
    output logic          cheio,
    output logic          ocupado,
    output logic          acertou,
    output logic          errou,
    output logic          fim_rodada
);

    localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int FW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [FW-1:0] C_ON_FIM  = FW'(T_ON - 1);
    localparam logic [FW-1:0] C_OFF_FIM = FW'(T_OFF - 1);

    if (T_ON < 1 || T_OFF < 1 || TIMEOUT < 1 || DEPTH != (1 << AW)) begin : g_parametro_invalido
        $error("sequencia_memoria: invalid parameter set");
    end

    typedef enum logic [1:0] {
        OCIOSO,
        MOSTRA_ON,
        MOSTRA_OFF,
        ESPERA_JOGADA
    } estado_t;

    function automatic logic f_um_quente(input logic [3:0] v);
        return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
    endfunction

    logic [3:0]    r_mem [DEPTH];
    estado_t       r_estado, w_prox_estado;
    logic [AW-1:0] r_idx, w_prox_idx, w_idx_inc;
    logic [FW-1:0] r_fase, w_prox_fase;
    logic [AW:0]   r_tamanho;
    logic [3:0]    r_leds, w_prox_leds;
    logic          r_acertou, r_errou, r_fim;
    logic          w_acertou, w_errou, w_fim;
    logic          w_cheio, w_escreve, w_ultimo;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] C_TIMEOUT_FIM = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_inativo, w_prox_inativo;
`endif

    assign w_cheio   = (r_tamanho == (AW+1)'(DEPTH));
    assign w_escreve = (r_estado == OCIOSO) && adiciona && f_um_quente(numero) && !w_cheio;
    assign w_ultimo  = ((AW+1)'(r_idx) + (AW+1)'(1)) == r_tamanho;
    assign w_idx_inc = r_idx + AW'(1);

    // Storage is never reset; only the length pointer is.
    always_ff @(posedge clock) begin
        if (w_escreve) begin
            r_mem[r_tamanho[AW-1:0]] <= numero;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        w_prox_idx    = r_idx;
        w_prox_fase   = r_fase;
        w_prox_leds   = 4'b0;
        w_acertou     = 1'b0;
        w_errou       = 1'b0;
        w_fim         = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        w_prox_inativo = '0;
`endif
        case (r_estado)
            OCIOSO: begin
                // A same-cycle append to an empty store makes numero the first element shown.
                if (mostra && (r_tamanho != '0 || w_escreve)) begin
                    w_prox_estado = MOSTRA_ON;
                    w_prox_idx    = '0;
                    w_prox_fase   = '0;
                    w_prox_leds   = (r_tamanho == '0) ? numero : r_mem[0];
                end
            end
            MOSTRA_ON: begin
                if (r_fase == C_ON_FIM) begin
                    w_prox_estado = MOSTRA_OFF;
                    w_prox_fase   = '0;
                end else begin
                    w_prox_fase = r_fase + FW'(1);
                    w_prox_leds = r_leds;
                end
            end
            MOSTRA_OFF: begin
                if (r_fase == C_OFF_FIM) begin
                    w_prox_fase = '0;
                    if (w_ultimo) begin
                        w_prox_estado = ESPERA_JOGADA;
                        w_prox_idx    = '0;
                    end else begin
                        w_prox_estado = MOSTRA_ON;
                        w_prox_idx    = w_idx_inc;
                        w_prox_leds   = r_mem[w_idx_inc];
                    end
                end else begin
                    w_prox_fase = r_fase + FW'(1);
                end
            end
            ESPERA_JOGADA: begin
                if (jogada_valida) begin
                    if (f_um_quente(jogada) && jogada == r_mem[r_idx]) begin
                        w_acertou = 1'b1;
                        if (w_ultimo) begin
                            w_fim         = 1'b1;
                            w_prox_estado = OCIOSO;
                            w_prox_idx    = '0;
                        end else begin
                            w_prox_idx = w_idx_inc;
                        end
                    end else begin
                        w_errou       = 1'b1;
                        w_prox_estado = OCIOSO;
                        w_prox_idx    = '0;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (r_inativo == C_TIMEOUT_FIM) begin
                    w_errou       = 1'b1;
                    w_prox_estado = OCIOSO;
                    w_prox_idx    = '0;
                end else begin
                    w_prox_inativo = r_inativo + TW'(1);
                end
`endif
            end
            default: begin
                w_prox_estado = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!zera_s_n) begin
            r_estado  <= OCIOSO;
            r_idx     <= '0;
            r_fase    <= '0;
            r_tamanho <= '0;
            r_leds    <= 4'b0;
            r_acertou <= 1'b0;
            r_errou   <= 1'b0;
            r_fim     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_inativo <= '0;
`endif
        end else begin
            r_estado  <= w_prox_estado;
            r_idx     <= w_prox_idx;
            r_fase    <= w_prox_fase;
            r_leds    <= w_prox_leds;
            r_acertou <= w_acertou;
            r_errou   <= w_errou;
            r_fim     <= w_fim;
            if (w_escreve) begin
                r_tamanho <= r_tamanho + (AW+1)'(1);
            end
`ifdef SEQ_TIMEOUT_EN
            r_inativo <= w_prox_inativo;
`endif
        end
    end

    assign leds       = r_leds;
    assign tamanho    = r_tamanho;
    assign cheio      = w_cheio;
    assign ocupado    = (r_estado != OCIOSO);
    assign acertou    = r_acertou;
    assign errou      = r_errou;
    assign fim_rodada = r_fim;

endmodule

// File: tb/tb_sequencia_memoria.sv
// Self-checking bench for sequencia_memoria: scoreboard of expected result pulses plus direct playback checks.
module tb_sequencia_memoria;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int P     = T_ON + T_OFF;

    logic          clock = 1'b0;
    logic          zera_s_n;
    logic          adiciona;
    logic [3:0]    numero;
    logic          mostra;
    logic [3:0]    jogada;
    logic          jogada_valida;
    logic [3:0]    leds;
    logic [AW:0]   tamanho;
    logic          cheio;
    logic          ocupado;
    logic          acertou;
    logic          errou;
    logic          fim_rodada;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] m_seq[$];
    int         m_idx = 0;
    logic [2:0] q_pulsos[$];

    sequencia_memoria #(
        .DEPTH(DEPTH), .AW(AW), .T_ON(T_ON), .T_OFF(T_OFF), .TIMEOUT(64)
    ) dut (
        .clock(clock),
        .zera_s_n(zera_s_n),
        .adiciona(adiciona),
        .numero(numero),
        .mostra(mostra),
        .jogada(jogada),
        .jogada_valida(jogada_valida),
        .leds(leds),
        .tamanho(tamanho),
        .cheio(cheio),
        .ocupado(ocupado),
        .acertou(acertou),
        .errou(errou),
        .fim_rodada(fim_rodada)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result pulses are {acertou, errou, fim_rodada}; each one must match the oldest queued expectation.
    always @(negedge clock) begin
        if (acertou || errou || fim_rodada) begin
            if (q_pulsos.size() == 0) begin
                check("unexpected_pulse", {29'b0, acertou, errou, fim_rodada}, 32'h0);
            end else begin
                check("pulse", {29'b0, acertou, errou, fim_rodada}, {29'b0, q_pulsos.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic adic(input logic [3:0] v);
        adiciona = 1'b1;
        numero   = v;
        if ($countones(v) == 1 && m_seq.size() < DEPTH) m_seq.push_back(v);
        tick();
        adiciona = 1'b0;
        numero   = 4'b0;
    endtask

    task automatic reproduz(input bit com_adic, input logic [3:0] v);
        logic [3:0] e;
        if (com_adic) begin
            adiciona = 1'b1;
            numero   = v;
            if ($countones(v) == 1 && m_seq.size() < DEPTH) m_seq.push_back(v);
        end
        mostra = 1'b1;
        tick();
        mostra   = 1'b0;
        adiciona = 1'b0;
        numero   = 4'b0;
        for (int c = 0; c < m_seq.size() * P; c++) begin
            e = ((c % P) < T_ON) ? m_seq[c / P] : 4'b0;
            check("leds_play", {28'b0, leds}, {28'b0, e});
            check("busy_play", {31'b0, ocupado}, 32'h1);
            tick();
        end
        check("leds_wait", {28'b0, leds}, 32'h0);
        check("busy_wait", {31'b0, ocupado}, 32'h1);
        m_idx = 0;
    endtask

    task automatic pressiona(input logic [3:0] v);
        logic [2:0] e;
        if (v == m_seq[m_idx]) begin
            if (m_idx == m_seq.size() - 1) begin
                e = 3'b101;
                m_idx = 0;
            end else begin
                e = 3'b100;
                m_idx++;
            end
        end else begin
            e = 3'b010;
            m_idx = 0;
        end
        q_pulsos.push_back(e);
        jogada        = v;
        jogada_valida = 1'b1;
        tick();
        jogada_valida = 1'b0;
        jogada        = 4'b0;
    endtask

    task automatic reinicia();
        zera_s_n = 1'b0;
        tick();
        zera_s_n = 1'b1;
        m_seq.delete();
        m_idx = 0;
    endtask

    initial begin
        int n;
        zera_s_n = 1'b0;
        adiciona = 1'b0;
        numero = 4'b0;
        mostra = 1'b0;
        jogada = 4'b0;
        jogada_valida = 1'b0;
        tick();
        tick();
        zera_s_n = 1'b1;

        check("rst_leds", {28'b0, leds}, 32'h0);
        check("rst_tamanho", {27'b0, tamanho}, 32'h0);
        check("rst_cheio", {31'b0, cheio}, 32'h0);
        check("rst_ocupado", {31'b0, ocupado}, 32'h0);
        check("rst_pulses", {29'b0, acertou, errou, fim_rodada}, 32'h0);

        adic(4'b1000);
        adic(4'b0100);
        adic(4'b0010);
        check("tamanho_3", {27'b0, tamanho}, 32'd3);

        reproduz(1'b0, 4'b0);
        pressiona(4'b1000);
        pressiona(4'b0100);
        pressiona(4'b0010);
        check("busy_after_round", {31'b0, ocupado}, 32'h0);
        check("fim_with_last", {31'b0, fim_rodada}, 32'h1);

        reproduz(1'b0, 4'b0);
        pressiona(4'b1000);
        pressiona(4'b0001);
        check("busy_after_error", {31'b0, ocupado}, 32'h0);
        check("tamanho_kept", {27'b0, tamanho}, 32'd3);

        jogada = 4'b1000;
        jogada_valida = 1'b1;
        tick();
        jogada_valida = 1'b0;
        jogada = 4'b0;
        tick();
        check("idle_press_ignored", {31'b0, ocupado}, 32'h0);

        mostra = 1'b1;
        tick();
        mostra = 1'b0;
        check("on_first", {28'b0, leds}, 32'h8);
        adiciona = 1'b1;
        numero = 4'b0001;
        tick();
        adiciona = 1'b0;
        numero = 4'b0;
        check("add_during_play", {27'b0, tamanho}, 32'd3);
        check("still_on", {28'b0, leds}, 32'h8);
        reinicia();
        check("midrst_leds", {28'b0, leds}, 32'h0);
        check("midrst_tamanho", {27'b0, tamanho}, 32'h0);
        check("midrst_ocupado", {31'b0, ocupado}, 32'h0);

        mostra = 1'b1;
        tick();
        mostra = 1'b0;
        check("empty_show_busy", {31'b0, ocupado}, 32'h0);
        tick();
        check("empty_show_leds", {28'b0, leds}, 32'h0);

        adic(4'b0110);
        check("non_onehot_add", {27'b0, tamanho}, 32'h0);

        reproduz(1'b1, 4'b0010);
        check("add_and_show", {27'b0, tamanho}, 32'd1);
        pressiona(4'b0010);
        check("single_round_end", {31'b0, ocupado}, 32'h0);

        reinicia();
        for (int i = 0; i < DEPTH + 1; i++) begin
            adic(4'b0001 << $urandom_range(0, 3));
            if (i == DEPTH - 2) check("cheio_at_15", {31'b0, cheio}, 32'h0);
        end
        check("tamanho_full", {27'b0, tamanho}, 32'd16);
        check("cheio_full", {31'b0, cheio}, 32'h1);

        reproduz(1'b0, 4'b0);
        for (int i = 0; i < DEPTH; i++) pressiona(m_seq[i]);
        check("full_round_end", {31'b0, ocupado}, 32'h0);

        reproduz(1'b0, 4'b0);
`ifdef SEQ_TIMEOUT_EN
        q_pulsos.push_back(3'b010);
        n = 0;
        while (n < 100 && !errou) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 32'd64);
        check("timeout_idle", {31'b0, ocupado}, 32'h0);
`else
        n = 0;
        repeat (1000) begin
            tick();
            n++;
        end
        check("no_timeout_busy", {31'b0, ocupado}, 32'h1);
        pressiona(m_seq[0]);
        pressiona(~m_seq[1]);
        check("non_onehot_press", {31'b0, ocupado}, 32'h0);
`endif

        tick();
        tick();
        check("queue_drained", q_pulsos.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
